// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants and helpers for the fetch stage
package riscv_pkg;

   localparam int              XLEN      = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

   // Instruction fetch is word granular, so drop the byte-offset bits
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with clear, used for fetch tags and fetched words
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   // Next-state: clear wins, otherwise push and pop may happen together (even when full)
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Storage is not reset; only pointers and count are
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, in-order imem reads, stale-drop on redirect (FETCH_PERF_EN adds perf counters)
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stallD,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instrF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPulse4F,
`ifdef FETCH_PERF_EN
   output logic [XLEN-1:0] perf_fetch_cnt,
   output logic [XLEN-1:0] perf_bubble_cnt,
`endif
   output logic            validF
);

   localparam int         CW      = $clog2(FIFO_DEPTH) + 1;
   localparam int         DW      = 8;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [DW-1:0]     drop_q, drop_d;
   logic [CW-1:0]     tag_count, buf_count;
   logic [XLEN-1:0]   tag_head;
   logic [2*XLEN-1:0] buf_head;
   logic [CW:0]       occ;
   logic              issue, rsp_take, rsp_keep, head_pop;

   // Handshake decode; occupancy credits this cycle's head pop so L=1 streams at full rate
   always_comb begin
      head_pop = (buf_count != '0) && !stallD;
      rsp_take = imem_rvalid && ((drop_q != '0) || (tag_count != '0));
      rsp_keep = imem_rvalid && (drop_q == '0) && (tag_count != '0);
      occ      = (CW+1)'(tag_count) + (CW+1)'(buf_count) - (CW+1)'(head_pop);
      issue    = rst_n && !redirect && (occ < DEPTH_C);
   end

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
      .clk(clk), .rst_n(rst_n), .clear(redirect),
      .push(issue), .push_data(pc_q), .pop(rsp_keep),
      .head_data(tag_head), .count(tag_count)
   );

   fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_instr_buf (
      .clk(clk), .rst_n(rst_n), .clear(redirect),
      .push(rsp_keep), .push_data({tag_head, imem_rdata}), .pop(head_pop),
      .head_data(buf_head), .count(buf_count)
   );

   // PC and stale-response count; redirect turns every tagged request into one to drop
   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if (redirect) begin
         pc_d   = word_align(redirect_pc);
         drop_d = drop_q + DW'(tag_count) - DW'(rsp_take);
      end else begin
         if (issue) begin
            pc_d = pc_q + PC_STEP;
         end
         if (imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - DW'(1);
         end
      end
   end

   // PC and drop counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   // A response with nothing outstanding is ignored by the datapath but flagged here
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(imem_rvalid && (drop_q == '0) && (tag_count == '0)));
      end
   end

   // Outputs come straight from the registered buffer head, squashed to a NOP when empty
   always_comb begin
      validF    = (buf_count != '0);
      instrF    = validF ? buf_head[XLEN-1:0]      : NOP_INSTR;
      PCF       = validF ? buf_head[2*XLEN-1:XLEN] : '0;
      PCPulse4F = validF ? (buf_head[2*XLEN-1:XLEN] + PC_STEP) : '0;
      imem_req  = issue;
      imem_addr = pc_q;
   end

`ifdef FETCH_PERF_EN
   logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

   // Delivered-word and empty-slot counters; redirect leaves them alone
   always_comb begin
      fetch_cnt_d  = fetch_cnt_q + XLEN'(head_pop);
      bubble_cnt_d = bubble_cnt_q + XLEN'(!validF && !stallD);
   end

   // Performance counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign perf_fetch_cnt  = fetch_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stallD;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instrF, PCF, PCPulse4F;
   logic        validF;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

   int checks = 0;
   int errors = 0;

   fetch_stage #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .stallD(stallD),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instrF(instrF), .PCF(PCF), .PCPulse4F(PCPulse4F),
`ifdef FETCH_PERF_EN
      .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
      .validF(validF)
   );

   always #5 clk = ~clk;

   // Instruction memory model: fixed latency, in order, data = ~address
   typedef struct {
      int          due;
      logic [31:0] addr;
   } req_t;
   req_t mq[$];
   req_t nr;
   int   cyc = 0;
   int   mem_lat = 1;

   always @(posedge clk) begin
      cyc++;
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (!rst_n) begin
         mq.delete();
      end else if (mq.size() > 0 && mq[0].due == cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = ~mq[0].addr;
         void'(mq.pop_front());
      end
   end

   always @(negedge clk) begin
      if (imem_req) begin
         nr.due  = cyc + mem_lat;
         nr.addr = imem_addr;
         mq.push_back(nr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input int lat);
      rst_n       = 1'b0;
      stallD      = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      mem_lat     = lat;
      tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset(1);
      #4;
      checks++;
      if ({imem_req, validF} !== 2'b00) begin
         errors++;
         $display("FAIL reset_req_valid got req=%b valid=%b want 0 0", imem_req, validF);
      end
      checks++;
      if ({instrF, PCF, PCPulse4F} !== {32'h0000_0013, 32'h0, 32'h0}) begin
         errors++;
         $display("FAIL reset_outputs got instr=%h pc=%h p4=%h want 00000013 0 0", instrF, PCF, PCPulse4F);
      end
   endtask

   task automatic test_stream();
      logic [31:0] ea, ep;
      do_reset(1);
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         #4;
         ea = 32'h100 + 32'(4 * (c - 1));
         checks++;
         if ({imem_req, imem_addr} !== {1'b1, ea}) begin
            errors++;
            $display("FAIL stream_req c=%0d got req=%b addr=%h want 1 %h", c, imem_req, imem_addr, ea);
         end
         if (c < 3) begin
            checks++;
            if (validF !== 1'b0) begin
               errors++;
               $display("FAIL stream_empty c=%0d got valid=%b want 0", c, validF);
            end
         end else begin
            ep = 32'h100 + 32'(4 * (c - 3));
            checks++;
            if ({validF, PCF, instrF, PCPulse4F} !== {1'b1, ep, ~ep, ep + 32'd4}) begin
               errors++;
               $display("FAIL stream_head c=%0d got v=%b pc=%h ins=%h p4=%h want pc=%h", c, validF, PCF, instrF, PCPulse4F, ep);
            end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset(1);
      rst_n = 1'b1;
      tick();
      tick();
      stallD = 1'b1;
      for (int c = 3; c <= 6; c++) begin
         #4;
         checks++;
         if ({validF, PCF, instrF, imem_req} !== {1'b1, 32'h100, ~32'h100, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold c=%0d got v=%b pc=%h ins=%h req=%b want pc=00000100 req=0", c, validF, PCF, instrF, imem_req);
         end
         tick();
      end
      stallD = 1'b0;
      #4;
      checks++;
      if ({PCF, imem_req, imem_addr} !== {32'h100, 1'b1, 32'h108}) begin
         errors++;
         $display("FAIL stall_release got pc=%h req=%b addr=%h want 100 1 108", PCF, imem_req, imem_addr);
      end
      tick();
      #4;
      checks++;
      if ({validF, PCF} !== {1'b1, 32'h104}) begin
         errors++;
         $display("FAIL stall_next1 got v=%b pc=%h want 1 104", validF, PCF);
      end
      tick();
      #4;
      checks++;
      if ({validF, PCF} !== {1'b1, 32'h108}) begin
         errors++;
         $display("FAIL stall_next2 got v=%b pc=%h want 1 108", validF, PCF);
      end
   endtask

   task automatic test_redirect_drop();
      do_reset(3);
      rst_n = 1'b1;
      tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      #4;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL drop_noissue got req=%b want 0", imem_req);
      end
      tick();
      redirect = 1'b0;
      for (int c = 4; c <= 7; c++) begin
         #4;
         checks++;
         if (validF !== 1'b0) begin
            errors++;
            $display("FAIL drop_stale c=%0d got v=%b pc=%h want v=0", c, validF, PCF);
         end
         if (c == 4) begin
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
               errors++;
               $display("FAIL drop_newreq got req=%b addr=%h want 1 200", imem_req, imem_addr);
            end
         end
         tick();
      end
      #4;
      checks++;
      if ({validF, PCF, instrF} !== {1'b1, 32'h200, ~32'h200}) begin
         errors++;
         $display("FAIL drop_first got v=%b pc=%h ins=%h want 1 200", validF, PCF, instrF);
      end
      tick();
      #4;
      checks++;
      if ({validF, PCF} !== {1'b1, 32'h204}) begin
         errors++;
         $display("FAIL drop_second got v=%b pc=%h want 1 204", validF, PCF);
      end
   endtask

   task automatic test_redirect_rvalid_stall();
      do_reset(1);
      rst_n = 1'b1;
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      stallD      = 1'b1;
      #4;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL coin_noissue got req=%b want 0", imem_req);
      end
      tick();
      redirect = 1'b0;
      stallD   = 1'b0;
      #4;
      checks++;
      if ({validF, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
         errors++;
         $display("FAIL coin_after got v=%b req=%b addr=%h want 0 1 200", validF, imem_req, imem_addr);
      end
      tick();
      #4;
      checks++;
      if (validF !== 1'b0) begin
         errors++;
         $display("FAIL coin_wait got v=%b pc=%h want 0", validF, PCF);
      end
      tick();
      #4;
      checks++;
      if ({validF, PCF, instrF} !== {1'b1, 32'h200, ~32'h200}) begin
         errors++;
         $display("FAIL coin_first got v=%b pc=%h ins=%h want 1 200", validF, PCF, instrF);
      end
      tick();
      #4;
      checks++;
      if ({validF, PCF} !== {1'b1, 32'h204}) begin
         errors++;
         $display("FAIL coin_second got v=%b pc=%h want 1 204", validF, PCF);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] ea, ep;
      do_reset(1);
      rst_n       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      for (int c = 2; c <= 6; c++) begin
         #4;
         if (c <= 4) begin
            ea = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, ea}) begin
               errors++;
               $display("FAIL wrap_req c=%0d got req=%b addr=%h want 1 %h", c, imem_req, imem_addr, ea);
            end
         end
         if (c >= 4) begin
            ep = 32'hFFFF_FFF8 + 32'(4 * (c - 4));
            checks++;
            if ({validF, PCF, PCPulse4F} !== {1'b1, ep, ep + 32'd4}) begin
               errors++;
               $display("FAIL wrap_head c=%0d got v=%b pc=%h p4=%h want pc=%h", c, validF, PCF, PCPulse4F, ep);
            end
         end
         tick();
      end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      do_reset(1);
      rst_n = 1'b1;
      #4;
      checks++;
      if ({perf_fetch_cnt, perf_bubble_cnt} !== 64'h0) begin
         errors++;
         $display("FAIL perf_reset got fetch=%0d bubble=%0d want 0 0", perf_fetch_cnt, perf_bubble_cnt);
      end
      for (int c = 1; c <= 12; c++) tick();
      stallD      = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      tick();
      stallD   = 1'b0;
      redirect = 1'b0;
      tick();
      #4;
      checks++;
      if ({perf_fetch_cnt, perf_bubble_cnt} !== {32'd10, 32'd3}) begin
         errors++;
         $display("FAIL perf_counts got fetch=%0d bubble=%0d want 10 3", perf_fetch_cnt, perf_bubble_cnt);
      end
   endtask
`endif

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      stallD      = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      tick();
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drop();
      test_redirect_rvalid_stall();
      test_wrap();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
